// File: rtl/mac_tx_stream_if.sv
// Upstream stream bundle of the transmit MAC: frame length and payload words,
// each on its own valid/ready handshake.
interface mac_tx_stream_if #(
  parameter int LEN_BITS = 9
);
  logic [LEN_BITS-1:0] len;
  logic                len_valid;
  logic                len_ready;
  logic [31:0]         data;
  logic                data_valid;
  logic                data_ready;

  // The queue feeding frames into the MAC.
  modport master (
    output len, len_valid, data, data_valid,
    input  len_ready, data_ready
  );

  // The MAC itself.
  modport slave (
    input  len, len_valid, data, data_valid,
    output len_ready, data_ready
  );
endinterface

// File: rtl/mac_tx_stream.sv
// Ethernet transmit MAC: turns a length plus a stream of 32-bit words into
// preamble/SFD, header, payload, padding and FCS on an RMII (2-bit) or MII
// (4-bit) PHY bus. Every field is handled as 32-bit words held in one shift
// register that is reloaded on the last cycle of each word.
module mac_tx_stream #(
  parameter int          PHY_BITS  = 2,   // 2 = RMII, 4 = MII; nothing else
  parameter int          LEN_BITS  = 9,
  parameter logic [15:0] ETHERTYPE = 16'h5139,
  parameter int          MIN_WORDS = 11,
  parameter int          IFG_BYTES = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_i,
  mac_tx_stream_if.slave      s_if,
  input  logic [47:0]         src_mac_i,
  input  logic [47:0]         dst_mac_i,
  output logic [PHY_BITS-1:0] txd_o,
  output logic                tx_en_o,
  output logic                busy_o,
  output logic                underrun_o,
  output logic [15:0]         seq_o
);

  localparam int WORD_CYC = 32 / PHY_BITS;
  localparam int CNT_W    = $clog2(WORD_CYC);
  // The IDLE cycle that takes the next length is itself a quiet cycle, so
  // GAP lasts one cycle less than the full inter-frame gap.
  localparam int GAP_CYC  = IFG_BYTES * 8 / PHY_BITS;
  localparam int GAP_W    = $clog2(GAP_CYC + 1);
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_HDR, S_PAY, S_PAD, S_FCS, S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;       // cycle within the current word
  logic [LEN_BITS-1:0] wcnt_q, wcnt_d;     // word within the current state
  logic [31:0]         sh_q, sh_d;         // word on the wire, next bits in the LSBs
  logic [31:0]         crc_q, crc_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [15:0]         seq_q, seq_d;
  logic                bad_q, bad_d;       // frame lost a word, FCS gets corrupted
  logic                underrun_q, underrun_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                word_end;
  logic                load_pay;
  logic [31:0]         fcs_word;

  // Reorder a word so that shifting right emits MSB byte first, LSB bit first.
  function automatic logic [31:0] wire_order(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Reflected CRC-32 over the PHY_BITS bits leaving this cycle, bit 0 first.
  function automatic logic [31:0] crc_step(input logic [31:0] c,
                                           input logic [PHY_BITS-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < PHY_BITS; i++)
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? CRC_POLY : 32'h0);
    return r;
  endfunction

  // Register all frame state; rst abandons any frame in flight.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      sh_q       <= '0;
      crc_q      <= '1;
      len_q      <= '0;
      seq_q      <= '0;
      bad_q      <= 1'b0;
      underrun_q <= 1'b0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      sh_q       <= sh_d;
      crc_q      <= crc_d;
      len_q      <= len_d;
      seq_q      <= seq_d;
      bad_q      <= bad_d;
      underrun_q <= underrun_d;
      gap_q      <= gap_d;
    end
  end

  // Next state, word sequencing, CRC update and handshakes.
  // NOTE: every variable gets a default before the case so that no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q + 1'b1;
    wcnt_d          = wcnt_q;
    sh_d            = sh_q >> PHY_BITS;
    crc_d           = crc_q;
    len_d           = len_q;
    seq_d           = seq_q;
    bad_d           = bad_q;
    underrun_d      = underrun_q;
    gap_d           = gap_q;
    load_pay        = 1'b0;
    s_if.len_ready  = 1'b0;
    s_if.data_ready = 1'b0;
    word_end        = (cnt_q == CNT_W'(WORD_CYC - 1));

    if (state_q inside {S_HDR, S_PAY, S_PAD})
      crc_d = crc_step(crc_q, sh_q[PHY_BITS-1:0]);
    // crc_d already includes the bits leaving this cycle.
    fcs_word = bad_q ? crc_d : ~crc_d;

    case (state_q)
      S_IDLE: begin
        cnt_d          = '0;
        s_if.len_ready = enable_i;
        if (enable_i && s_if.len_valid) begin
          len_d   = s_if.len;
          bad_d   = 1'b0;
          crc_d   = '1;
          wcnt_d  = '0;
          sh_d    = wire_order(32'h55555555);
          state_d = S_PRE;
        end
      end
      S_PRE: if (word_end) begin
        if (wcnt_q == '0) begin
          wcnt_d = wcnt_q + 1'b1;
          sh_d   = wire_order(32'h555555D5);
        end else begin
          wcnt_d  = '0;
          sh_d    = wire_order(dst_mac_i[47:16]);
          state_d = S_HDR;
        end
      end
      S_HDR: if (word_end) begin
        wcnt_d = wcnt_q + 1'b1;
        case (wcnt_q[1:0])
          2'd0:    sh_d = wire_order({dst_mac_i[15:0], src_mac_i[47:32]});
          2'd1:    sh_d = wire_order(src_mac_i[31:0]);
          2'd2:    sh_d = wire_order({ETHERTYPE, seq_q});
          default: begin
            seq_d    = seq_q + 1'b1;
            wcnt_d   = '0;
            load_pay = 1'b1;
            state_d  = S_PAY;
          end
        endcase
      end
      S_PAY: if (word_end) begin
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == len_q - 1'b1) begin
          wcnt_d = '0;
          if (len_q < LEN_BITS'(MIN_WORDS)) begin
            sh_d    = '1;
            state_d = S_PAD;
          end else begin
            sh_d    = fcs_word;
            state_d = S_FCS;
          end
        end else begin
          load_pay = 1'b1;
        end
      end
      S_PAD: if (word_end) begin
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == LEN_BITS'(MIN_WORDS) - len_q - 1'b1) begin
          wcnt_d  = '0;
          sh_d    = fcs_word;
          state_d = S_FCS;
        end else begin
          sh_d = '1;
        end
      end
      S_FCS: if (word_end) begin
        gap_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        cnt_d = '0;
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_W'(GAP_CYC - 2)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The payload word is taken in the last cycle of the previous word; a
    // missing word is replaced by all-ones and the frame is poisoned.
    if (load_pay) begin
      s_if.data_ready = 1'b1;
      if (s_if.data_valid) begin
        sh_d = wire_order(s_if.data);
      end else begin
        sh_d       = '1;
        bad_d      = 1'b1;
        underrun_d = 1'b1;
      end
    end

    if (rst) begin
      s_if.len_ready  = 1'b0;
      s_if.data_ready = 1'b0;
    end
  end

  assign tx_en_o    = (state_q inside {S_PRE, S_HDR, S_PAY, S_PAD, S_FCS});
  assign txd_o      = tx_en_o ? sh_q[PHY_BITS-1:0] : '0;
  assign busy_o     = (state_q != S_IDLE);
  assign underrun_o = underrun_q;
  assign seq_o      = seq_q;

endmodule

// File: tb/tb_mac_tx_stream.sv
// Bench for mac_tx_stream: an RMII and an MII instance, driven frame by frame
// from a vector table, with the received wire bytes compared against a frame
// built here and checked by an independent CRC receiver.
module tb_mac_tx_stream;

  localparam int MIN_WORDS = 11;

  typedef struct {
    bit          mii;
    int          len;
    int          drop;          // payload word index sent without data_valid, -1 = none
    bit          b2b;           // follows the previous frame with no idle time
    int          exp_txen;
    bit          exp_underrun;
    bit          exp_fcs_ok;
    logic [15:0] exp_seq;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en2 = 1'b0;
  logic        en4 = 1'b0;
  logic [8:0]  len_v = '0;
  logic        len_valid = 1'b0;
  logic [31:0] data_v = '0;
  logic        data_valid = 1'b0;
  logic [47:0] dst = 48'h0A1B2C3D4E5F;
  logic [47:0] src = 48'h021122334455;

  logic [1:0]  txd2;
  logic [3:0]  txd4;
  logic        tx_en2, tx_en4, busy2, busy4, und2, und4;
  logic [15:0] seq2, seq4;

  mac_tx_stream_if #(.LEN_BITS(9)) if2 ();
  mac_tx_stream_if #(.LEN_BITS(9)) if4 ();

  assign if2.len = len_v;    assign if2.len_valid = len_valid;
  assign if2.data = data_v;  assign if2.data_valid = data_valid;
  assign if4.len = len_v;    assign if4.len_valid = len_valid;
  assign if4.data = data_v;  assign if4.data_valid = data_valid;

  mac_tx_stream #(.PHY_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .enable_i(en2), .s_if(if2),
    .src_mac_i(src), .dst_mac_i(dst), .txd_o(txd2), .tx_en_o(tx_en2),
    .busy_o(busy2), .underrun_o(und2), .seq_o(seq2)
  );

  mac_tx_stream #(.PHY_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .enable_i(en4), .s_if(if4),
    .src_mac_i(src), .dst_mac_i(dst), .txd_o(txd4), .tx_en_o(tx_en4),
    .busy_o(busy4), .underrun_o(und4), .seq_o(seq4)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int pre_gap = 0;   // quiet samples already seen at the end of the previous frame

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    return 32'h01020304 + 32'(i) * 32'h04040404;
  endfunction

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Send one frame, capture the wire, and compare with the expected frame.
  task automatic apply_vec(input int idx, input vec_t v);
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    logic [31:0] crc, w;
    logic [7:0]  cur = '0;
    logic [3:0]  td;
    logic [15:0] seqf;
    int nb = 0, txen_cyc = 0, cyc = 0, widx = 0, gap, nmis = 0, first_mis = -1, pb;
    bit started = 0, done = 0, hs_len, hs_dat, te, rx_ok;
    string tag;
    tag = $sformatf("v%0d", idx);
    pb  = v.mii ? 4 : 2;
    gap = pre_gap;

    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) exp_q.push_back(dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) exp_q.push_back(src[8*i +: 8]);
    exp_q.push_back(8'h51);
    exp_q.push_back(8'h39);
    exp_q.push_back(v.exp_seq[15:8]);
    exp_q.push_back(v.exp_seq[7:0]);
    for (int i = 0; i < v.len; i++) begin
      w = (i == v.drop) ? 32'hFFFFFFFF : word_of(i);
      for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    end
    for (int i = v.len; i < MIN_WORDS; i++) repeat (4) exp_q.push_back(8'hFF);
    crc = 32'hFFFFFFFF;
    for (int i = 8; i < exp_q.size(); i++) crc = crc_byte(crc, exp_q[i]);
    if (v.drop < 0) crc = ~crc;
    for (int b = 0; b < 4; b++) exp_q.push_back(crc[8*b +: 8]);

    @(posedge clk); #1;
    en2 = !v.mii;
    en4 = v.mii;
    len_v = 9'(v.len);
    len_valid = 1'b1;
    data_v = word_of(0);
    data_valid = (v.drop != 0);
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      hs_len = len_valid && (v.mii ? if4.len_ready : if2.len_ready);
      hs_dat = v.mii ? if4.data_ready : if2.data_ready;
      te     = v.mii ? tx_en4 : tx_en2;
      td     = v.mii ? txd4 : {2'b00, txd2};
      if (te) begin
        started = 1;
        txen_cyc++;
        for (int k = 0; k < pb; k++) begin
          cur = {td[k], cur[7:1]};
          nb++;
          if (nb == 8) begin rx_q.push_back(cur); nb = 0; end
        end
      end else if (started) begin
        done = 1;
      end else begin
        gap++;
      end
      if (!done) begin
        @(posedge clk); #1;
        if (hs_len) len_valid = 1'b0;
        if (hs_dat) begin
          widx++;
          data_v = word_of(widx);
          data_valid = (widx != v.drop);
        end
      end
    end
    pre_gap = 1;

    check({tag, "_frame_done"}, done, 1);
    check({tag, "_txen_cycles"}, txen_cyc, v.exp_txen);
    check({tag, "_byte_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) begin
        nmis++;
        if (first_mis < 0) first_mis = i;
      end
    check($sformatf("%s_bad_bytes_first_at_%0d", tag, first_mis), nmis, 0);
    seqf = (rx_q.size() >= 24) ? {rx_q[22], rx_q[23]} : 16'hxxxx;
    check({tag, "_seq_field"}, seqf, v.exp_seq);
    crc = 32'hFFFFFFFF;
    for (int i = 8; i < rx_q.size(); i++) crc = crc_byte(crc, rx_q[i]);
    rx_ok = (rx_q.size() > 12) && (crc == 32'hDEBB20E3);
    check({tag, "_rx_fcs_ok"}, rx_ok, v.exp_fcs_ok);
    check({tag, "_underrun"}, v.mii ? und4 : und2, v.exp_underrun);
    if (v.b2b) check({tag, "_ifg_cycles"}, gap, 48);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t post;
    int   viol, pulses;
    //          mii len drop b2b txen und fcs seq
    vecs[0] = '{0, 20, -1, 0, 432, 0, 1, 16'h0000};
    vecs[1] = '{0, 20, -1, 1, 432, 0, 1, 16'h0001};
    vecs[2] = '{0,  3,  1, 0, 288, 1, 0, 16'h0002};
    vecs[3] = '{0,  1, -1, 0, 288, 1, 1, 16'h0003};
    vecs[4] = '{1, 11, -1, 0, 144, 0, 1, 16'h0000};
    post    = '{0,  1, -1, 0, 288, 0, 1, 16'h0000};

    // Reset state, with enable high to show len_ready is still held low.
    en2 = 1'b1;
    en4 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_en", tx_en2, 0);
    check("rst_txd", txd2, 0);
    check("rst_busy", busy2, 0);
    check("rst_underrun", und2, 0);
    check("rst_seq", seq2, 0);
    check("rst_len_ready", if2.len_ready, 0);
    check("rst_data_ready", if2.data_ready, 0);
    check("rst_tx_en_mii", tx_en4, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    en2 = 1'b0;
    en4 = 1'b0;

    for (int i = 0; i < 5; i++) apply_vec(i, vecs[i]);

    // enable low holds off a pending length; raising it starts the frame.
    @(posedge clk); #1;
    en2 = 1'b0;
    en4 = 1'b0;
    len_v = 9'd4;
    len_valid = 1'b1;
    data_v = word_of(0);
    data_valid = 1'b1;
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (if2.len_ready || tx_en2 || if4.len_ready || tx_en4) viol++;
    end
    check("enable_low_holds_idle", viol, 0);
    @(posedge clk); #1;
    en2 = 1'b1;
    @(negedge clk);
    check("len_ready_on_enable", if2.len_ready, 1);
    @(posedge clk); #1;
    len_valid = 1'b0;
    @(negedge clk);
    check("tx_en_after_accept", tx_en2, 1);
    check("busy_after_accept", busy2, 1);

    // Run into the payload, then reset in the middle of it.
    pulses = 0;
    for (int i = 0; i < 200 && pulses < 2; i++) begin
      @(negedge clk);
      if (if2.data_ready) pulses++;
    end
    check("payload_reached", pulses, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("tx_en_until_rst_sampled", tx_en2, 1);
    @(negedge clk);
    check("midrst_tx_en", tx_en2, 0);
    check("midrst_txd", txd2, 0);
    check("midrst_busy", busy2, 0);
    check("midrst_seq", seq2, 0);
    check("midrst_underrun", und2, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    pre_gap = 0;
    apply_vec(5, post);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
